// File: rtl/swervolf_uart_monitor.sv
// UART receive monitor: 2-flop synchronizer, 8-bit frame FSM, show-ahead byte FIFO, sticky error flags.
// Define UART_MON_PARITY_EN to expect an even-parity bit between the data and the stop bit.
module swervolf_uart_monitor #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_uart_rx,
  output logic [7:0]       o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [FIFO_AW:0] o_level,
  output logic             o_frame_err,
  output logic             o_parity_err,
  output logic             o_overflow,
  input  logic             i_clr
);

  localparam int            CW    = $clog2(CLKS_PER_BIT + 1);
  localparam int            DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_e;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  logic meta_q, rxs_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= i_uart_rx;
      rxs_q  <= meta_q;
    end
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push, frame_set;
`ifdef UART_MON_PARITY_EN
  logic          par_bad_q, par_bad_d, par_set;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef UART_MON_PARITY_EN
    par_bad_d = par_bad_q;
    par_set   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_MON_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_MON_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d     = '0;
          par_bad_d = rxs_q ^ (^shift_q);
          par_set   = par_bad_d;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            // Straight to IDLE so a start bit right after the stop bit is caught.
            state_d = IDLE;
`ifdef UART_MON_PARITY_EN
            push    = !par_bad_q;
`else
            push    = 1'b1;
`endif
          end else begin
            frame_set = 1'b1;
            state_d   = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_IDLE: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // FIFO: extra pointer MSB separates full from empty.
  logic [FIFO_AW:0] wr_q, rd_q;
  logic [7:0]       mem_q [DEPTH];
  logic             empty, full, pop, wr_en, ovf_set;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) &&
                   (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
  assign pop     = !empty && i_ready;
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[FIFO_AW-1:0]] <= shift_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
    end
  end

  assign o_valid = !empty;
  assign o_data  = empty ? 8'h00 : mem_q[rd_q[FIFO_AW-1:0]];
  assign o_level = wr_q - rd_q;

  // Sticky flags: a new event in the clear cycle keeps the flag set.
  logic frame_err_q, overflow_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      frame_err_q <= (frame_err_q & ~i_clr) | frame_set;
      overflow_q  <= (overflow_q & ~i_clr) | ovf_set;
    end
  end
  assign o_frame_err = frame_err_q;
  assign o_overflow  = overflow_q;

`ifdef UART_MON_PARITY_EN
  logic par_err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bad_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      par_err_q <= (par_err_q & ~i_clr) | par_set;
    end
  end
  assign o_parity_err = par_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_swervolf_uart_monitor.sv
// Directed frames into the UART monitor; popped bytes are checked against an expected-byte queue.
module tb_swervolf_uart_monitor;
  localparam int CPB = 4;
  localparam int AW  = 2;

  logic          clk = 1'b0, rst = 1'b1, rx = 1'b1, rdy = 1'b0, clr = 1'b0;
  logic [7:0]    o_data;
  logic          o_valid, o_frame_err, o_parity_err, o_overflow;
  logic [AW:0]   o_level;

  int         checks = 0, failures = 0;
  logic [7:0] sb [$];

  swervolf_uart_monitor #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst), .i_uart_rx(rx),
    .o_data(o_data), .o_valid(o_valid), .i_ready(rdy), .o_level(o_level),
    .o_frame_err(o_frame_err), .o_parity_err(o_parity_err), .o_overflow(o_overflow),
    .i_clr(clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Drives one frame starting at a negedge; returns at the negedge ending the stop bit.
  task automatic send(input logic [7:0] b, input logic stop, input logic flip, input logic exp_push);
    if (exp_push) sb.push_back(b);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_MON_PARITY_EN
    rx = (^b) ^ flip;
    repeat (CPB) @(negedge clk);
`else
    if (flip) $display("note: parity flip ignored in 8N1 build");
`endif
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Monitor: just before each rising edge, a handshake must pop the oldest expected byte.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (o_valid && rdy) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected actual=%0h expected=none", o_data);
        end else begin
          check("pop_data", int'(o_data), int'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_level", o_level, 0);
    check("rst_flags", {o_frame_err, o_parity_err, o_overflow}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte: no bypass, valid one cycle after the stop sample.
    send(8'h55, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("no_bypass_valid", o_valid, 0);
    @(negedge clk);
    check("b55_valid", o_valid, 1);
    check("b55_data", o_data, 8'h55);
    check("b55_level", o_level, 1);
    rdy = 1'b1;
    @(negedge clk);
    check("pop_valid", o_valid, 0);
    check("pop_level", o_level, 0);
    check("pop_data_zero", o_data, 0);

    // One-clock glitch is not a start bit.
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_valid", o_valid, 0);
    check("glitch_level", o_level, 0);

    // Bad stop bit, then a good frame, then clear.
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("ferr_set", o_frame_err, 1);
    check("ferr_level", o_level, 0);
    repeat (4) @(negedge clk);
    send(8'h3C, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("ferr_sticky", o_frame_err, 1);
    pulse_clr();
    check("ferr_clr", o_frame_err, 0);

    // Overflow: five frames into a four-entry FIFO.
    rdy = 1'b0;
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0, i <= 4);
    repeat (2) @(negedge clk);
    check("ovf_level", o_level, 4);
    check("ovf_flag", o_overflow, 1);
    check("ovf_head", o_data, 8'h01);
    pulse_clr();
    check("ovf_clr", o_overflow, 0);

    // Full FIFO with push and pop in the same cycle: both accepted.
    send(8'h06, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    check("full_pp_level", o_level, 4);
    check("full_pp_ovf", o_overflow, 0);
    check("full_pp_head", o_data, 8'h02);
    rdy = 1'b1;
    repeat (6) @(negedge clk);
    check("drain_level", o_level, 0);
    check("drain_valid", o_valid, 0);

    // Back-to-back frames with no idle gap.
    send(8'h12, 1'b1, 1'b0, 1'b1);
    send(8'h34, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("b2b_errs", {o_frame_err, o_parity_err, o_overflow}, 0);
    check("b2b_level", o_level, 0);

`ifdef UART_MON_PARITY_EN
    send(8'h03, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("par_err_set", o_parity_err, 1);
    check("par_err_level", o_level, 0);
    rdy = 1'b0;
    send(8'h03, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("par_ok_valid", o_valid, 1);
    check("par_ok_data", o_data, 8'h03);
    rdy = 1'b1;
    repeat (2) @(negedge clk);
    pulse_clr();
    check("par_err_clr", o_parity_err, 0);
`else
    check("par_tied", o_parity_err, 0);
`endif

    // Reset mid-frame aborts without a push; the next frame is received normally.
    rx = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_valid", o_valid, 0);
    rx  = 1'b1;
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("midrst_level", o_level, 0);
    send(8'h5A, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/swervolf_uart_monitor.md
SWERVOLF_UART_MONITOR -- requirements
Module: swervolf_uart_monitor

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200).
REQ-002 SHALL have parameter FIFO_AW, default 4, log2 of receive FIFO depth (16 entries).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_uart_rx  input  1  asynchronous serial line, driven by the SoC UART TX output.
REQ-006 SHALL have port o_data  output  8  FIFO head byte; 8'h00 when o_valid=0.
REQ-007 SHALL have port o_valid  output  1  FIFO non-empty.
REQ-008 SHALL have port i_ready  input  1  consumer pops head when o_valid&i_ready.
REQ-009 SHALL have port o_level  output  FIFO_AW+1  FIFO occupancy, 0..2^FIFO_AW.
REQ-010 SHALL have port o_frame_err  output  1  sticky, stop bit sampled 0.
REQ-011 SHALL have port o_parity_err  output  1  sticky, parity mismatch (see REQ-030).
REQ-012 SHALL have port o_overflow  output  1  sticky, byte dropped on full FIFO.
REQ-013 SHALL have port i_clr  input  1  one-cycle pulse clearing all sticky flags.

Function
REQ-014 SHALL pass i_uart_rx through a 2-flop synchronizer; all timing below is relative to the synchronized line (rxs).
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-016 IDLE: rxs=0 -> START with bit counter cleared to 0.
REQ-017 START: at count CLKS_PER_BIT/2 (integer division) sample rxs; 1 -> IDLE (glitch, nothing pushed); 0 -> DATA, counter cleared.
REQ-018 DATA: sample rxs every CLKS_PER_BIT cycles, 8 samples, LSB first, into a shift register.
REQ-019 After 8th data sample SHALL go to PARITY when the macro is defined, else to STOP.
REQ-020 STOP: sample after CLKS_PER_BIT cycles; 1 -> push byte (unless parity error) and go IDLE in the same cycle, so back-to-back frames with zero idle gap are received.
REQ-021 STOP sampled 0 -> set o_frame_err, discard byte, go WAIT_IDLE; WAIT_IDLE -> IDLE when rxs=1.
REQ-022 FIFO write SHALL occur on the clock edge after the stop-sample cycle; o_valid rises that edge when the FIFO was empty (no combinational bypass).
REQ-023 FIFO SHALL be show-ahead; pop on o_valid&i_ready; o_level updates on the same edge.
REQ-024 Push when full and no pop: byte dropped, o_overflow set, contents unchanged.
REQ-025 Push and pop in the same cycle when full: both accepted, o_level stays 2^FIFO_AW, o_overflow not set.
REQ-026 Pointers SHALL wrap modulo 2^FIFO_AW; full/empty SHALL be distinguished by the extra pointer bit.
REQ-027 i_clr and a new error event in the same cycle: flag ends set (set wins).

Reset
REQ-028 On rst: FSM=IDLE, counters 0, shift register 0, synchronizer flops 1, FIFO empty, o_valid=0, o_data=8'h00, o_level=0, all sticky flags 0.
REQ-029 rst asserted mid-frame SHALL abort the frame with no push; after release reception restarts only on a new falling edge.

Configuration
REQ-030 Macro UART_MON_PARITY_EN defined: frame is start, 8 data, even-parity bit, stop; PARITY samples after CLKS_PER_BIT; mismatch sets o_parity_err, byte discarded, STOP still checked.
REQ-031 Macro UART_MON_PARITY_EN undefined: 8N1 framing, PARITY state unreachable, o_parity_err tied 0.

Verification (CLKS_PER_BIT=4, FIFO_AW=2)
REQ-032 Reset, send 0x55 8N1 -> o_valid=1, o_data=0x55, o_level=1 one cycle after stop sample; i_ready=1 -> o_valid=0, o_level=0, o_data=0x00.
REQ-033 Line low for 1 bit-period/4 (1 clk) -> no push, o_valid stays 0, FSM back to IDLE.
REQ-034 Send 0xA5 with stop bit 0 -> o_frame_err=1, o_level=0; line high, then 0x3C -> pushed; i_clr -> o_frame_err=0.
REQ-035 Send 0x01..0x05 with i_ready=0 -> o_level=4, o_overflow=1; drain reads 01,02,03,04.
REQ-036 Send 0x12, 0x34 with zero idle gap -> both captured in order, no errors.
REQ-037 With UART_MON_PARITY_EN: 0x03 with parity bit 1 -> o_parity_err=1, no push; 0x03 with parity 0 -> pushed, o_data=0x03.
